// File: rtl/adder_pkg.sv
// Shared types and helpers for the segmented, pipelined adder.
package adder_pkg;

  // Control fields that travel with every beat between segment stages.
  typedef struct packed {
    logic valid;
    logic sub;
    logic carry;
  } stage_ctrl_t;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry segment; also exposes the carry into its MSB.
module adder_segment #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder; the building block of every segment ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chained segments, one per register
// stage, behind a valid/ready stream interface with full backpressure.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Handshake: a beat moves from producer to consumer on a cycle where valid and
  // ready are both 1; ready never depends on the data inputs.
  localparam int SEG  = seg_w(WIDTH, STAGES);
  localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

  if ((STAGES < 1) || (WIDTH % STAGES != 0)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
  end

  logic adv;

  // Stage inputs: index 0 comes from the ports, index k from register k-1.
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_s   [STAGES];
  stage_ctrl_t      st_ctrl[STAGES];

  logic [SEG-1:0]    seg_s [STAGES];
  logic [STAGES-1:0] seg_co;
  logic [STAGES-1:0] seg_cm;
  logic [WIDTH-1:0]  nx_s  [STAGES];

  // Skew registers between segments: raw operands, partial sum, control.
  logic [WIDTH-1:0] mid_a_q   [NMID];
  logic [WIDTH-1:0] mid_a_d   [NMID];
  logic [WIDTH-1:0] mid_b_q   [NMID];
  logic [WIDTH-1:0] mid_b_d   [NMID];
  logic [WIDTH-1:0] mid_s_q   [NMID];
  logic [WIDTH-1:0] mid_s_d   [NMID];
  stage_ctrl_t      mid_ctrl_q[NMID];
  stage_ctrl_t      mid_ctrl_d[NMID];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !rst;

  always_comb begin
    st_a[0]          = in1;
    st_b[0]          = in2;
    st_s[0]          = '0;
    st_ctrl[0].valid = in_valid && in_ready;
    st_ctrl[0].sub   = sub;
    st_ctrl[0].carry = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k]    = mid_a_q[k-1];
      st_b[k]    = mid_b_q[k-1];
      st_s[k]    = mid_s_q[k-1];
      st_ctrl[k] = mid_ctrl_q[k-1];
    end
  end

  // B is stored raw; each segment inverts its own slice using the beat's sub bit.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_segment #(.SEG(SEG)) u_seg (
      .a        (st_a[k][k*SEG +: SEG]),
      .b        (st_b[k][k*SEG +: SEG] ^ {SEG{st_ctrl[k].sub}}),
      .ci       (st_ctrl[k].carry),
      .s        (seg_s[k]),
      .co       (seg_co[k]),
      .c_msb_in (seg_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nx_s[k]              = st_s[k];
      nx_s[k][k*SEG +: SEG] = seg_s[k];
    end
  end

  always_comb begin
    for (int k = 0; k < NMID; k++) begin
      mid_a_d[k]    = '0;
      mid_b_d[k]    = '0;
      mid_s_d[k]    = '0;
      mid_ctrl_d[k] = '0;
      if (k < STAGES - 1) begin
        mid_a_d[k]          = st_a[k];
        mid_b_d[k]          = st_b[k];
        mid_s_d[k]          = nx_s[k];
        mid_ctrl_d[k].valid = st_ctrl[k].valid;
        mid_ctrl_d[k].sub   = st_ctrl[k].sub;
        mid_ctrl_d[k].carry = seg_co[k];
      end
    end
  end

  // Bubbles still load the output registers; only out_valid says whether they matter.
  always_comb begin
    out_valid_d = st_ctrl[STAGES-1].valid;
    sum_d       = nx_s[STAGES-1];
    cout_d      = seg_co[STAGES-1];
    ovf_d       = seg_co[STAGES-1] ^ seg_cm[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NMID; k++) begin
        mid_a_q[k]    <= '0;
        mid_b_q[k]    <= '0;
        mid_s_q[k]    <= '0;
        mid_ctrl_q[k] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NMID; k++) begin
        mid_a_q[k]    <= mid_a_d[k];
        mid_b_q[k]    <= mid_b_d[k];
        mid_s_q[k]    <= mid_s_d[k];
        mid_ctrl_q[k] <= mid_ctrl_d[k];
      end
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
